// File: rtl/ling_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ling_pkg : shared defaults for the Ling-adder arbiter slice.  Rev 1.0
// ---------------------------------------------------------------------------
package ling_pkg;

  localparam int DEFAULT_WIDTH = 16;

  // Id width for n requesters; never narrower than one bit.
  function automatic int idw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_ling.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_ling : combinational Ling adder, Kogge-Stone prefix on pseudo-carries.
// Rev 1.0
// ---------------------------------------------------------------------------
module adder_ling
  import ling_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic [WIDTH:0]   sum
);

  localparam int LV = $clog2(WIDTH);

  logic [WIDTH-1:0] t;
  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] h;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] hn;
  logic [WIDTH-1:0] qn;
  logic [WIDTH-1:0] c;

  // H[i] = g[i] | t[i-1]&H[i-1]; real carry into bit i+1 is t[i]&H[i].
  always_comb begin
    t = x | y;
    p = x ^ y;
    h = x & y;
    q = '0;
    for (int i = 1; i < WIDTH; i++) q[i] = t[i-1];
    for (int k = 0; k < LV; k++) begin
      hn = h;
      qn = q;
      for (int i = 0; i < WIDTH; i++) begin
        if (i >= (1 << k)) begin
          hn[i] = h[i] | (q[i] & h[i-(1<<k)]);
          qn[i] = q[i] & q[i-(1<<k)];
        end
      end
      h = hn;
      q = qn;
    end
    c = '0;
    for (int i = 1; i < WIDTH; i++) c[i] = t[i-1] & h[i-1];
    sum = {t[WIDTH-1] & h[WIDTH-1], p ^ c};
  end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rr_arbiter : combinational round-robin grant, search upward from ptr.  Rev 1.0
// ---------------------------------------------------------------------------
module rr_arbiter
  import ling_pkg::*;
#(
  parameter int N   = 4,
  parameter int IDW = idw(N)
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  input  logic           en,
  output logic [N-1:0]   gnt
);

  logic found;

  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        gnt[idx] = en;
        found    = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ling_add_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ling_add_arbiter : N requesters share one Ling adder, registered response.
// Rev 1.0
// ---------------------------------------------------------------------------
module ling_add_arbiter
  import ling_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int N     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req_valid,
  input  logic [N*WIDTH-1:0]   req_x,
  input  logic [N*WIDTH-1:0]   req_y,
  output logic [N-1:0]         req_ready,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [idw(N)-1:0]    rsp_id,
  output logic [WIDTH:0]       rsp_sum
);

  localparam int IDW = idw(N);

  logic             free;
  logic             xfer;
  logic [N-1:0]     gnt;
  logic [IDW-1:0]   ptr;
  logic [IDW-1:0]   gnt_idx;
  logic [WIDTH-1:0] op_x;
  logic [WIDTH-1:0] op_y;
  logic [WIDTH:0]   add_sum;

  assign free = !rsp_valid || rsp_ready;

  // Nothing is accepted while reset is asserted.
  rr_arbiter #(.N(N), .IDW(IDW)) u_arb (
    .req (req_valid),
    .ptr (ptr),
    .en  (free && !rst),
    .gnt (gnt)
  );

  assign req_ready = gnt;
  assign xfer      = |gnt;

  always_comb begin
    op_x    = '0;
    op_y    = '0;
    gnt_idx = '0;
    for (int i = 0; i < N; i++) begin
      if (gnt[i]) begin
        op_x    = op_x | req_x[i*WIDTH +: WIDTH];
        op_y    = op_y | req_y[i*WIDTH +: WIDTH];
        gnt_idx = IDW'(i);
      end
    end
  end

  adder_ling #(.WIDTH(WIDTH)) u_add (
    .x   (op_x),
    .y   (op_y),
    .sum (add_sum)
  );

  generate
    if (N > 1) begin : g_ptr_reg
      always_ff @(posedge clk) begin
        if (rst)
          ptr <= '0;
        else if (xfer)
          ptr <= (int'(gnt_idx) == N-1) ? '0 : gnt_idx + IDW'(1);
      end
    end else begin : g_ptr_const
      assign ptr = '0;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_id    <= gnt_idx;
      rsp_sum   <= add_sum;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ling_add_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ling_add_arbiter : directed + random checks against a behavioural model.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_ling_add_arbiter;

  localparam int W = 16;
  localparam int N = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_x;
  logic [N*W-1:0]   req_y;
  logic [N-1:0]     req_ready;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_id;
  logic [W:0]       rsp_sum;

  ling_add_arbiter #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Model: the response register and the round-robin pointer.
  int         m_ptr;
  logic       m_valid;
  int         m_id;
  logic [W:0] m_sum;
  int         last_g;

  logic [N-1:0] obs_gnt;
  logic         obs_valid;
  logic [1:0]   obs_id;
  logic [W:0]   obs_sum;
  logic [1:0]   obs_ptr;
  logic [W:0]   held_sum;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int model_grant();
    if (rst || !(!m_valid || rsp_ready)) return -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (req_valid[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [W-1:0] x, input logic [W-1:0] y);
    req_valid[i]      = v;
    req_x[i*W +: W]   = x;
    req_y[i*W +: W]   = y;
  endtask

  task automatic step();
    int g;
    logic [N-1:0] exp_gnt;
    @(negedge clk);
    g = model_grant();
    exp_gnt = '0;
    if (g >= 0) exp_gnt[g] = 1'b1;
    obs_gnt   = req_ready;
    obs_valid = rsp_valid;
    obs_id    = rsp_id;
    obs_sum   = rsp_sum;
    obs_ptr   = dut.ptr;
    check("req_ready", 32'(req_ready), 32'(exp_gnt));
    check("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check("rsp_id",    32'(rsp_id),    32'(m_id));
    check("rsp_sum",   32'(rsp_sum),   32'(m_sum));
    check("ptr",       32'(dut.ptr),   32'(m_ptr));
    last_g = g;
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_id = 0; m_sum = '0; m_ptr = 0;
    end else if (g >= 0) begin
      m_valid = 1'b1;
      m_id    = g;
      m_sum   = {1'b0, req_x[g*W +: W]} + {1'b0, req_y[g*W +: W]};
      m_ptr   = (g + 1) % N;
    end else if (rsp_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; req_valid = '0; req_x = '0; req_y = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    m_ptr = 0; m_valid = 1'b0; m_id = 0; m_sum = '0; last_g = -1;
    step();
    check("reset_valid", 32'(obs_valid), 32'd0);
    rst = 1'b0;

    // Single request
    rsp_ready = 1'b1;
    set_req(2, 1'b1, 16'h1234, 16'h0FF1);
    step();
    check("t1_gnt", 32'(obs_gnt), 32'h4);
    set_req(2, 1'b0, 16'h0, 16'h0);
    step();
    check("t1_valid", 32'(obs_valid), 32'd1);
    check("t1_id",    32'(obs_id),    32'd2);
    check("t1_sum",   32'(obs_sum),   32'h02225);
    check("t1_ptr",   32'(obs_ptr),   32'd3);

    // Carry-out
    set_req(0, 1'b1, 16'hFFFF, 16'hFFFF);
    step();
    set_req(0, 1'b1, 16'hFFFF, 16'h0001);
    step();
    check("t2_sum_a", 32'(obs_sum), 32'h1FFFE);
    set_req(0, 1'b0, 16'h0, 16'h0);
    step();
    check("t2_sum_b", 32'(obs_sum), 32'h10000);

    // All four valid from ptr=0
    rst = 1'b1; step(); rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < N; i++) set_req(i, 1'b1, W'($urandom), W'($urandom));
      step();
      check("rr_gnt", 32'(obs_gnt), 32'(1 << (k % 4)));
      if (k > 0) check("rr_id", 32'(obs_id), 32'((k - 1) % 4));
    end

    // Backpressure with a response pending
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      if (k == 0) held_sum = obs_sum;
      check("bp_gnt", 32'(obs_gnt), 32'd0);
      check("bp_id",  32'(obs_id),  32'd3);
      check("bp_sum", 32'(obs_sum), 32'(held_sum));
    end
    rsp_ready = 1'b1;
    step();
    check("bp_release_gnt", 32'(obs_gnt), 32'h1);
    step();
    check("bp_release_valid", 32'(obs_valid), 32'd1);
    check("bp_release_id",    32'(obs_id),    32'd0);

    // Pointer wrap between requesters 3 and 0
    req_valid = '0;
    set_req(2, 1'b1, 16'h0001, 16'h0002);
    step();
    req_valid = 4'b1001;
    step(); check("wrap_0", 32'(obs_gnt), 32'h8);
    step(); check("wrap_1", 32'(obs_gnt), 32'h1);
    step(); check("wrap_2", 32'(obs_gnt), 32'h8);

    // Reset while a stalled response is held
    req_valid = 4'b0010;
    step();
    req_valid = '0; rsp_ready = 1'b0;
    step();
    check("rm_held", 32'(obs_valid), 32'd1);
    rst = 1'b1; req_valid = 4'b1111;
    step();
    check("rm_no_accept", 32'(obs_gnt), 32'd0);
    rst = 1'b0; req_valid = '0;
    step();
    check("rm_valid", 32'(obs_valid), 32'd0);
    check("rm_sum",   32'(obs_sum),   32'd0);
    check("rm_ptr",   32'(obs_ptr),   32'd0);

    // Random traffic; accepted requesters may reload, others hold
    for (int c = 0; c < 400; c++) begin
      rsp_ready = ($urandom % 4) != 0;
      rst = ($urandom % 64) == 0;
      step();
      for (int i = 0; i < N; i++) begin
        if (i == last_g || !req_valid[i]) begin
          if ($urandom % 8 == 0)
            set_req(i, ($urandom % 2) == 1, 16'hFFFF, W'($urandom));
          else
            set_req(i, ($urandom % 2) == 1, W'($urandom), W'($urandom));
        end
      end
    end
    rst = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ling_add_arbiter.md
# ling_add_arbiter

Round-robin arbiter sharing one combinational Ling adder (`adder_ling`) among N requesters. Each requester presents an operand pair with a valid/ready handshake. The winner's operands are added in the same cycle, and the (WIDTH+1)-bit sum is captured in a single registered response stage tagged with the requester id. The block sits between the operand-producing units and the one physical adder, so area stays at one adder regardless of requester count.

## Interface
- `WIDTH`, 16, operand width in bits; passed to `adder_ling`.
- `N`, 4, number of requesters, N ≥ 1.
- `IDW`, localparam, max(1, $clog2(N)), width of the response id.

Reset is synchronous and active-high. One clock.

- `clk` in 1: sole clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in N: bit i set means requester i has operands ready.
- `req_x` in N*WIDTH: requester i's x operand in bits [i*WIDTH +: WIDTH].
- `req_y` in N*WIDTH: requester i's y operand, packed the same way.
- `req_ready` out N: one-hot or zero; bit i set means requester i is accepted this cycle.
- `rsp_valid` out 1: the response register holds a result.
- `rsp_ready` in 1: the consumer accepts the response this cycle.
- `rsp_id` out IDW: index of the requester that owns the response.
- `rsp_sum` out WIDTH+1: x+y for that requester, carry-out in the MSB.

## Operation
- Stage free condition: `free = !rsp_valid || rsp_ready`.
- Grant:
  - When `free` is true, grant the first requester with `req_valid` set, searching upward from pointer `ptr` with wrap from N-1 to 0.
  - `req_ready` is the one-hot grant ANDed with `free`. It is zero when no requester is valid or `free` is false.
- Transfer: request i transfers when `req_valid[i] && req_ready[i]`.
- Datapath:
  - The granted requester's x/y are muxed to `adder_ling`.
  - Its full (WIDTH+1)-bit sum is captured into `rsp_sum`, with the grant index captured into `rsp_id`, and `rsp_valid` is set.
  - There is no truncation and no carry-in.
- Pointer update: on a transfer from requester i, `ptr` becomes (i+1) mod N. Otherwise `ptr` holds.
- Response handshake:
  - A response completes when `rsp_valid && rsp_ready`.
  - If a completion occurs with no new transfer, `rsp_valid` clears.
  - A completion and a new transfer in the same cycle overwrite the register, and `rsp_valid` stays 1.
- Stall: while `rsp_valid && !rsp_ready`, `rsp_id`/`rsp_sum` hold stable and `req_ready` is all zero.
- Requester rules:
  - A requester must hold its valid and operands until it sees ready.
  - `req_valid` must not depend on `req_ready`.
  - `req_ready` may depend combinationally on `req_valid` and `rsp_ready`.
- N = 1: the pointer is constant 0 and the block degenerates to a one-entry registered adder.

## Timing
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `ptr`=0. `req_ready` is 0 during the reset cycle.
- Latency: a request accepted in cycle t produces `rsp_valid`=1 with its result in cycle t+1.
- Throughput: one result per cycle while `rsp_ready` is held high.
- Fairness: with all N requesters valid continuously and no stalls, each is granted exactly once per N cycles.
- Reset mid-operation:
  - Any held response is discarded and `ptr` returns to 0.
  - A request presented during the reset cycle is not accepted.
- Combinational paths: the grant-mux-adder path ends at the response register. The combinational paths to outputs are `req_valid`→`req_ready` and `rsp_ready`→`req_ready`.

## Structure
- The shared package `ling_pkg` holds the default WIDTH and the function `idw(n)` that returns max(1, $clog2(n)).
- Sub-module `rr_arbiter` (N): inputs `req`, `ptr`, `en`; output one-hot `gnt`; purely combinational.
- The top level instantiates `rr_arbiter`, the operand mux and one `adder_ling`, and owns the `ptr` and response registers.

## Test plan
All scenarios use WIDTH=16, N=4.
1. Single request: requester 2 issues 0x1234+0x0FF1 with `rsp_ready`=1. The next cycle shows `rsp_valid`=1, `rsp_id`=2, `rsp_sum`=0x02225; `ptr`=3.
2. Carry-out: 0xFFFF+0xFFFF gives `rsp_sum`=0x1FFFE. 0xFFFF+0x0001 gives 0x10000.
3. All four requesters valid for 8 cycles with `rsp_ready`=1 and `ptr` starting at 0: grant order is 0,1,2,3,0,1,2,3, and each `rsp_id` matches its grant one cycle later.
4. Backpressure: hold `rsp_ready`=0 for 3 cycles with a response pending. `req_ready`=0 throughout and `rsp_sum`/`rsp_id` are unchanged. On the cycle `rsp_ready`=1 is raised, the next grant occurs and the register is overwritten with `rsp_valid` still 1.
5. Pointer wrap: only requesters 3 and 0 are valid and `ptr`=3. Grant 3, then 0, then 3.
6. Reset mid-stream: assert `rst` while `rsp_valid`=1 and `rsp_ready`=0. The next cycle shows `rsp_valid`=0, `rsp_sum`=0, `ptr`=0, and no request is accepted in the reset cycle.
